// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: load types, FSM states, IO window base.
package wb_pkg;

  // Load type encodings carried down the pipeline with each load
  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_BU = 3'd2;
  localparam logic [2:0] LD_H  = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  // Write-back controller states
  typedef enum logic {
    S_IDLE    = 1'b0,
    S_WAIT_IO = 1'b1
  } wb_state_t;

  // Base of the IO window; the MEM stage compares against this to raise mem_is_io
  localparam logic [31:0] IO_BASE = 32'hFFFFFC00;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load aligner: picks the addressed byte/half and sign- or zero-extends it.
module wb_load_align
  import wb_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_ldtype,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and half; addr_lo[0] is irrelevant for halves
  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  // Extend according to load type; unknown encodings behave like a word load
  always_comb begin
    o_result = i_word;
    case (i_ldtype)
      LD_B:    o_result = {{24{w_byte[7]}}, w_byte};
      LD_BU:   o_result = {24'd0, w_byte};
      LD_H:    o_result = {{16{w_half[15]}}, w_half};
      LD_HU:   o_result = {16'd0, w_half};
      default: o_result = i_word;
    endcase
  end

endmodule

// File: rtl/wb_writeback.sv
// Write-back stage: registers MEM results onto the register-file write port and runs
// IO-space loads through a req/ack handshake, stalling upstream until ack or timeout.
module wb_writeback
  import wb_pkg::*;
#(
  parameter int IO_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_regwrite,
  input  logic        mem_memtoreg,
  input  logic        mem_is_io,
  input  logic [2:0]  mem_ldtype,
  input  logic [1:0]  mem_addr_lo,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rdata,
  output logic        io_req,
  input  logic        io_ack,
  input  logic [31:0] io_rdata,
  output logic        wb_stall,
  output logic        RegWrite,
  output logic [4:0]  Waddr,
  output logic [31:0] Wdata,
  output logic        io_timeout
);

  localparam int TW = $clog2(IO_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(IO_TIMEOUT - 1);

  wb_state_t   r_state;
  logic [TW-1:0] r_timer;
  logic [4:0]  r_io_waddr;
  logic [2:0]  r_io_ldtype;
  logic [1:0]  r_io_addr_lo;
  logic        r_io_regwrite;
  logic        r_regwrite;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;
  logic        r_io_timeout;

  logic        w_waiting;
  logic [31:0] w_align_word;
  logic [2:0]  w_align_ldtype;
  logic [1:0]  w_align_addr_lo;
  logic [31:0] w_aligned;

  // While waiting on IO the single aligner works on the IO word with the latched load info
  always_comb begin
    w_waiting       = (r_state == S_WAIT_IO);
    w_align_word    = w_waiting ? io_rdata     : mem_rdata;
    w_align_ldtype  = w_waiting ? r_io_ldtype  : mem_ldtype;
    w_align_addr_lo = w_waiting ? r_io_addr_lo : mem_addr_lo;
  end

  wb_load_align u_align (
    .i_word    (w_align_word),
    .i_ldtype  (w_align_ldtype),
    .i_addr_lo (w_align_addr_lo),
    .o_result  (w_aligned)
  );

  // Write-back FSM: direct writes from IDLE, IO loads wait for ack or abort on timeout
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_io_waddr    <= 5'd0;
      r_io_ldtype   <= LD_W;
      r_io_addr_lo  <= 2'd0;
      r_io_regwrite <= 1'b0;
      r_regwrite    <= 1'b0;
      r_waddr       <= 5'd0;
      r_wdata       <= 32'd0;
      r_io_timeout  <= 1'b0;
    end else begin
      r_io_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mem_valid) begin
            if (mem_memtoreg && mem_is_io) begin
              r_io_waddr    <= mem_waddr;
              r_io_ldtype   <= mem_ldtype;
              r_io_addr_lo  <= mem_addr_lo;
              r_io_regwrite <= mem_regwrite;
              r_regwrite    <= 1'b0;
              r_timer       <= '0;
              r_state       <= S_WAIT_IO;
            end else begin
              r_regwrite <= mem_regwrite && (mem_waddr != 5'd0);
              r_waddr    <= mem_waddr;
              r_wdata    <= mem_memtoreg ? w_aligned : mem_alu_result;
            end
          end else begin
            r_regwrite <= 1'b0;
          end
        end
        S_WAIT_IO: begin
          if (io_ack) begin
            r_regwrite <= r_io_regwrite && (r_io_waddr != 5'd0);
            r_waddr    <= r_io_waddr;
            r_wdata    <= w_aligned;
            r_state    <= S_IDLE;
          end else if (r_timer == TIMER_LAST) begin
            r_regwrite   <= 1'b0;
            r_io_timeout <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
      endcase
    end
  end

  assign io_req     = w_waiting;
  assign wb_stall   = w_waiting;
  assign RegWrite   = r_regwrite;
  assign Waddr      = r_waddr;
  assign Wdata      = r_wdata;
  assign io_timeout = r_io_timeout;

endmodule

// File: tb/tb_wb_writeback.sv
// Scoreboard bench for wb_writeback: stimulus queues expected writes, a monitor checks them.
module tb_wb_writeback;
  import wb_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_valid, mem_regwrite, mem_memtoreg, mem_is_io;
  logic [2:0]  mem_ldtype;
  logic [1:0]  mem_addr_lo;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_alu_result, mem_rdata;
  logic        io_req, io_ack;
  logic [31:0] io_rdata;
  logic        wb_stall, RegWrite, io_timeout;
  logic [4:0]  Waddr;
  logic [31:0] Wdata;

  always #5 clock = ~clock;

  wb_writeback #(.IO_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
    .mem_is_io(mem_is_io), .mem_ldtype(mem_ldtype), .mem_addr_lo(mem_addr_lo),
    .mem_waddr(mem_waddr), .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
    .io_req(io_req), .io_ack(io_ack), .io_rdata(io_rdata),
    .wb_stall(wb_stall), .RegWrite(RegWrite), .Waddr(Waddr), .Wdata(Wdata),
    .io_timeout(io_timeout)
  );

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every register-file write must match the oldest queued expectation
  always @(negedge clock) begin
    if (!reset && RegWrite) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual waddr=%0d wdata=%h required no write", Waddr, Wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("write cyc=%0d waddr=%0d wdata=%h (expected waddr=%0d wdata=%h cyc=%0d)",
                 cyc, Waddr, Wdata, e.waddr, e.wdata, e.cyc);
        chk("write_waddr", {27'd0, Waddr}, {27'd0, e.waddr});
        chk("write_wdata", Wdata, e.wdata);
        chk("write_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_mem(input logic rw, input logic m2r, input logic isio, input logic [2:0] lt,
                         input logic [1:0] lo, input logic [4:0] wa, input logic [31:0] alu,
                         input logic [31:0] rd);
    mem_valid = 1'b1; mem_regwrite = rw; mem_memtoreg = m2r; mem_is_io = isio;
    mem_ldtype = lt; mem_addr_lo = lo; mem_waddr = wa; mem_alu_result = alu; mem_rdata = rd;
  endtask

  // One-cycle MEM instruction; expw says whether a write with value expd should follow
  task automatic issue(input logic rw, input logic m2r, input logic isio, input logic [2:0] lt,
                       input logic [1:0] lo, input logic [4:0] wa, input logic [31:0] alu,
                       input logic [31:0] rd, input logic [31:0] expd, input bit expw);
    set_mem(rw, m2r, isio, lt, lo, wa, alu, rd);
    if (expw) exp_q.push_back('{wa, expd, cyc + 1});
    $display("issue waddr=%0d ldtype=%0d lo=%0d m2r=%0b io=%0b", wa, lt, lo, m2r, isio);
    step();
    mem_valid = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_io_req"}, {31'd0, io_req}, 32'd0);
    chk({tag, "_wb_stall"}, {31'd0, wb_stall}, 32'd0);
    chk({tag, "_io_timeout"}, {31'd0, io_timeout}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    mem_valid = 0; mem_regwrite = 0; mem_memtoreg = 0; mem_is_io = 0;
    mem_ldtype = LD_W; mem_addr_lo = 0; mem_waddr = 0; mem_alu_result = 0; mem_rdata = 0;
    io_ack = 0; io_rdata = 0;
    step(); step();
    // Reset state
    chk("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_Waddr", {27'd0, Waddr}, 32'd0);
    chk("rst_Wdata", Wdata, 32'd0);
    chk_idle_outputs("rst");
    reset = 1'b0;
    step();

    // ALU write
    issue(1, 0, 0, LD_W, 2'd0, 5'd5, 32'h1234, 32'h0, 32'h0000_1234, 1);
    // Loads of 0x80FF7F01 (back to back)
    issue(1, 1, 0, LD_B,  2'd3, 5'd10, 32'h0, 32'h80FF7F01, 32'hFFFF_FF80, 1);
    issue(1, 1, 0, LD_BU, 2'd3, 5'd11, 32'h0, 32'h80FF7F01, 32'h0000_0080, 1);
    issue(1, 1, 0, LD_H,  2'd2, 5'd12, 32'h0, 32'h80FF7F01, 32'hFFFF_80FF, 1);
    issue(1, 1, 0, LD_HU, 2'd0, 5'd13, 32'h0, 32'h80FF7F01, 32'h0000_7F01, 1);
    issue(1, 1, 0, LD_W,  2'd0, 5'd14, 32'h0, 32'h80FF7F01, 32'h80FF_7F01, 1);
    issue(1, 1, 0, LD_B,  2'd1, 5'd15, 32'h0, 32'h80FF7F01, 32'h0000_007F, 1);
    issue(1, 1, 0, LD_H,  2'd3, 5'd16, 32'h0, 32'h80FF7F01, 32'hFFFF_80FF, 1);
    issue(1, 1, 0, LD_HU, 2'd1, 5'd17, 32'h0, 32'h80FF7F01, 32'h0000_7F01, 1);
    issue(1, 1, 0, LD_W,  2'd2, 5'd18, 32'h0, 32'h80FF7F01, 32'h80FF_7F01, 1);
    issue(1, 1, 0, LD_BU, 2'd0, 5'd19, 32'h0, 32'h80FF7F01, 32'h0000_0001, 1);
    // $0 guard and regwrite=0: no write expected
    issue(1, 0, 0, LD_W, 2'd0, 5'd0, 32'hDEAD, 32'h0, 32'h0, 0);
    chk("zero_RegWrite", {31'd0, RegWrite}, 32'd0);
    step();
    // Idle cycle: Waddr/Wdata hold the last registered values
    chk("hold_Waddr", {27'd0, Waddr}, 32'd0);
    chk("hold_Wdata", Wdata, 32'h0000_DEAD);
    issue(0, 0, 0, LD_W, 2'd0, 5'd7, 32'h7777, 32'h0, 32'h0, 0);
    // io_ack while idle is ignored
    io_ack = 1; io_rdata = 32'h1111_1111;
    step();
    io_ack = 0;
    chk_idle_outputs("idle_ack");
    step();

    // IO load, ack after 5 waiting cycles; next instruction held upstream meanwhile
    issue(1, 1, 1, LD_BU, 2'd0, 5'd9, 32'h0, 32'hBBBB_BBBB, 32'h0, 0);
    set_mem(1, 0, 0, LD_W, 2'd0, 5'd3, 32'h55, 32'h0);
    for (int k = 0; k < 6; k++) begin
      chk("io_req_wait", {31'd0, io_req}, 32'd1);
      chk("io_stall_wait", {31'd0, wb_stall}, 32'd1);
      if (k == 5) begin
        io_ack = 1; io_rdata = 32'h0000_00A5;
        exp_q.push_back('{5'd9, 32'h0000_00A5, cyc + 1});
      end else begin
        io_rdata = 32'hEEEE_EE00 + 32'(k);
      end
      step();
    end
    io_ack = 0;
    chk_idle_outputs("io_done");
    exp_q.push_back('{5'd3, 32'h0000_0055, cyc + 1});
    step();
    mem_valid = 0;
    step();

    // IO timeout after 8 stalled cycles
    issue(1, 1, 1, LD_W, 2'd0, 5'd12, 32'h0, 32'h0, 32'h0, 0);
    for (int k = 0; k < 8; k++) begin
      chk("to_stall", {31'd0, wb_stall}, 32'd1);
      chk("to_pulse_early", {31'd0, io_timeout}, 32'd0);
      step();
    end
    chk("to_stall_end", {31'd0, wb_stall}, 32'd0);
    chk("to_pulse", {31'd0, io_timeout}, 32'd1);
    chk("to_RegWrite", {31'd0, RegWrite}, 32'd0);
    step();
    chk("to_pulse_len", {31'd0, io_timeout}, 32'd0);
    step();

    // Reset during WAIT_IO, then a late ack
    issue(1, 1, 1, LD_W, 2'd0, 5'd15, 32'h0, 32'h0, 32'h0, 0);
    step();
    chk("pre_rst_stall", {31'd0, wb_stall}, 32'd1);
    reset = 1;
    step();
    reset = 0;
    chk("midrst_RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("midrst_Waddr", {27'd0, Waddr}, 32'd0);
    chk("midrst_Wdata", Wdata, 32'd0);
    chk_idle_outputs("midrst");
    io_ack = 1; io_rdata = 32'hCAFE_BABE;
    step();
    io_ack = 0;
    chk_idle_outputs("late_ack");
    chk("late_ack_Wdata", Wdata, 32'd0);
    step(); step();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
